// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, redirect
// handling with stale-response discard, and a one-entry hold stage for decode.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   redirect_valid, redirect_pc    taken branch/jump from execute
//   imem_req_valid/ready, imem_addr    request channel to instruction memory
//   imem_rsp_valid, imem_rsp_data      response pulse from instruction memory
//   if_valid/ready, if_pc, if_instr    fetched instruction handed to decode
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;

    logic [31:0] redir_tgt;

    assign redir_tgt = {redirect_pc[31:2], 2'b00};

    // Handshake outputs are masked while rst is held so nothing is
    // offered or accepted before the state register has been cleared.
    assign imem_req_valid = (state_q == S_REQ) && !rst;
    assign imem_addr      = pc_q;
    assign if_valid       = (state_q == S_HOLD) && !rst;
    assign if_pc          = if_pc_q;
    assign if_instr       = if_instr_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        discard_d  = discard_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;

        unique case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d = redir_tgt;
                    // An accepted request still returns a response;
                    // it belongs to the old path and must be dropped.
                    if (imem_req_ready) begin
                        discard_d = 1'b1;
                        state_d   = S_WAIT;
                    end
                end else if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redir_tgt;
                    if (imem_rsp_valid) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        discard_d = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        if_pc_d    = pc_q;
                        if_instr_d = imem_rsp_data;
                        state_d    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redir_tgt;
                    state_d = S_REQ;
                end else if (if_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            discard_q  <= 1'b0;
            if_pc_q    <= 32'd0;
            if_instr_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            discard_q  <= discard_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a response scoreboard.
// A second instance with a wrapping reset PC shares all inputs.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    logic        w_imem_req_valid;
    logic [31:0] w_imem_addr;
    logic        w_if_valid;
    logic [31:0] w_if_pc;
    logic [31:0] w_if_instr;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fetch_ctrl u_dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (w_imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (w_imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (w_if_valid),
        .if_ready       (if_ready),
        .if_pc          (w_if_pc),
        .if_instr       (w_if_instr)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic respond(input logic [31:0] a, input bit keep);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem(a);
        if (keep) sb.push_back('{pc: a, instr: mem(a)});
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
    endtask

    task automatic check_hold(input string tag);
        exp_t e;
        chk({tag, "_if_valid"}, 32'(if_valid), 32'd1);
        chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_if_pc"}, if_pc, e.pc);
            chk({tag, "_if_instr"}, if_instr, e.instr);
        end
    endtask

    task automatic fetch_one(input logic [31:0] a, input string tag);
        chk({tag, "_req"}, 32'(imem_req_valid), 32'd1);
        chk({tag, "_addr"}, imem_addr, a);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        chk({tag, "_wait"}, 32'(imem_req_valid), 32'd0);
        respond(a, 1'b1);
        check_hold(tag);
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_req_masked", 32'(imem_req_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_req", 32'(imem_req_valid), 32'd1);
        chk("post_rst_addr", imem_addr, 32'd0);
        chk("post_rst_if_valid", 32'(if_valid), 32'd0);
        chk("post_rst_if_pc", if_pc, 32'd0);
        chk("post_rst_if_instr", if_instr, 32'd0);
    endtask

    initial begin
        int last_cyc;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        if_ready       = 1'b0;
        last_cyc       = 0;

        do_reset();
        chk("wrap_reset_addr", w_imem_addr, 32'hFFFF_FFFC);

        // straight line: everything always ready, 3 cycles per instr
        imem_req_ready = 1'b1;
        if_ready       = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("sl_req", 32'(imem_req_valid), 32'd1);
            chk("sl_addr", imem_addr, 32'(i * 4));
            step();
            chk("sl_wait", 32'(imem_req_valid), 32'd0);
            respond(32'(i * 4), 1'b1);
            check_hold("sl");
            if (i == 0) chk("wrap_if_pc", w_if_pc, 32'hFFFF_FFFC);
            if (i > 0) chk("sl_period", 32'(cyc - last_cyc), 32'd3);
            last_cyc = cyc;
            step();
            if (i == 0) chk("wrap_next_addr", w_imem_addr, 32'd0);
        end
        imem_req_ready = 1'b0;
        if_ready       = 1'b0;

        // backpressure on the second instruction
        do_reset();
        fetch_one(32'h0, "bp0");
        chk("bp_addr", imem_addr, 32'h4);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        respond(32'h4, 1'b1);
        check_hold("bp1");
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_if_valid", 32'(if_valid), 32'd1);
            chk("bp_if_pc", if_pc, 32'h4);
            chk("bp_if_instr", if_instr, mem(32'h4));
            chk("bp_no_req", 32'(imem_req_valid), 32'd0);
        end
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
        chk("bp_next_addr", imem_addr, 32'h8);

        // redirect in REQ without handshake
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        step();
        redirect_valid = 1'b0;
        chk("rreq_req", 32'(imem_req_valid), 32'd1);
        chk("rreq_addr", imem_addr, 32'h400);

        // stray response in REQ is ignored
        respond(32'h999, 1'b0);
        chk("stray_req", 32'(imem_req_valid), 32'd1);
        chk("stray_if_valid", 32'(if_valid), 32'd0);
        chk("stray_addr", imem_addr, 32'h400);

        // redirect coinciding with the request handshake
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        chk("rhs_wait", 32'(imem_req_valid), 32'd0);
        respond(32'h400, 1'b0);
        chk("rhs_if_valid", 32'(if_valid), 32'd0);
        chk("rhs_addr", imem_addr, 32'h300);

        // redirect in WAIT, then stale response
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        chk("rwait_still_wait", 32'(imem_req_valid), 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_DEAD;
        step();
        imem_rsp_valid = 1'b0;
        chk("rwait_if_valid", 32'(if_valid), 32'd0);
        chk("rwait_addr", imem_addr, 32'h100);
        fetch_one(32'h100, "rwait_fetch");

        // redirect coinciding with the response
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h500;
        respond(32'h104, 1'b0);
        redirect_valid = 1'b0;
        chk("rrsp_if_valid", 32'(if_valid), 32'd0);
        chk("rrsp_req", 32'(imem_req_valid), 32'd1);
        chk("rrsp_addr", imem_addr, 32'h500);

        // redirect in HOLD with if_ready, misaligned target
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        respond(32'h500, 1'b1);
        check_hold("rhold");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        if_ready       = 1'b1;
        step();
        redirect_valid = 1'b0;
        if_ready       = 1'b0;
        chk("rhold_if_valid", 32'(if_valid), 32'd0);
        chk("rhold_addr", imem_addr, 32'h200);
        fetch_one(32'h200, "rhold_fetch");

        // reset in HOLD overrides a redirect
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        respond(32'h204, 1'b1);
        check_hold("rsth");
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h700;
        if_ready       = 1'b1;
        step();
        chk("rsth_if_valid", 32'(if_valid), 32'd0);
        chk("rsth_addr", imem_addr, 32'h0);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        if_ready       = 1'b0;
        #1;
        chk("rsth_req", 32'(imem_req_valid), 32'd1);
        chk("rsth_if_valid2", 32'(if_valid), 32'd0);
        fetch_one(32'h0, "rsth_fetch");

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning: PC loaded on reset.
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 redirect_valid  input  1  taken branch/jump from execute; highest priority.
REQ-005 redirect_pc  input  32  redirect target; bits [1:0] ignored, forced to 0.
REQ-006 imem_req_valid  output  1  instruction-memory request valid.
REQ-007 imem_req_ready  input  1  memory accepts request when high with imem_req_valid.
REQ-008 imem_addr  output  32  request address, equal to current PC.
REQ-009 imem_rsp_valid  input  1  one-cycle pulse; instruction data returned.
REQ-010 imem_rsp_data  input  32  returned instruction word.
REQ-011 if_valid  output  1  fetched instruction available to decode.
REQ-012 if_ready  input  1  decode consumes when high with if_valid.
REQ-013 if_pc  output  32  PC of presented instruction.
REQ-014 if_instr  output  32  presented instruction word.

Function
REQ-015 FSM states: REQ, WAIT, HOLD; state and all registers update only on posedge clk.
REQ-016 REQ: imem_req_valid=1, imem_addr=pc; on imem_req_ready -> WAIT; else stay REQ with pc unchanged.
REQ-017 WAIT: imem_req_valid=0; on imem_rsp_valid with discard=0 -> latch if_instr=imem_rsp_data, if_pc=pc, go HOLD.
REQ-018 WAIT with imem_rsp_valid and discard=1 -> drop data, clear discard, go REQ.
REQ-019 HOLD: if_valid=1, if_pc/if_instr stable; on if_ready -> pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC->0), go REQ.
REQ-020 if_valid SHALL be 1 only in HOLD; imem_req_valid SHALL be 1 only in REQ.
REQ-021 Redirect in REQ without handshake: pc<=redirect_pc, stay REQ; new address driven next cycle.
REQ-022 Redirect in REQ coinciding with handshake: request (old address) still counts as issued; pc<=redirect_pc, discard<=1, go WAIT.
REQ-023 Redirect in WAIT without response: pc<=redirect_pc, discard<=1, stay WAIT.
REQ-024 Redirect in WAIT coinciding with imem_rsp_valid: response dropped, pc<=redirect_pc, discard<=0, go REQ.
REQ-025 Redirect in HOLD (with or without if_ready): presented instruction is killed, no +4 increment, pc<=redirect_pc, go REQ.
REQ-026 At most one outstanding memory request; no new request before the pending response returns.
REQ-027 imem_rsp_valid in REQ or HOLD is a protocol error and SHALL be ignored.
REQ-028 Fetch-to-issue latency: request accepted in cycle N, response in cycle M>N -> if_valid=1 from cycle M+1.

Reset
REQ-029 rst high at a posedge: state<=REQ, pc<=RESET_PC, discard<=0, if_pc<=0, if_instr<=0; rst overrides redirect_valid and all handshakes.
REQ-030 During and in the cycle after rst: if_valid=0; imem_req_valid=1 with imem_addr=RESET_PC in the first cycle after rst deasserts.
REQ-031 Reset in WAIT: pending response arriving after reset SHALL be ignored only if it arrives while state is not WAIT; the memory is reset concurrently, so no stale response is expected.

Verification
REQ-032 Straight-line: ready always 1, rsp 1 cycle after accept, if_ready=1 -> if_pc sequence 0,4,8,C, one instruction every 3 cycles.
REQ-033 Backpressure: if_ready=0 for 5 cycles in HOLD -> if_valid, if_pc=0x4, if_instr held stable; no imem request issued.
REQ-034 Redirect in WAIT to 0x100, then rsp data 0xDEAD -> data dropped, next imem_addr=0x100, next if_pc=0x100.
REQ-035 Redirect in HOLD to 0x203 with if_ready=1 -> no consumption counted, next imem_addr=0x200.
REQ-036 Wrap: RESET_PC=0xFFFF_FFFC, consume one instruction -> next imem_addr=0x0000_0000.
REQ-037 rst asserted in HOLD with redirect_valid=1 -> next cycle if_valid=0, imem_addr=RESET_PC.
